fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning instruction buffer entries; legal values are 2 and 4.
REQ-003 SHALL have parameter KEY_FETCH, default 8'b10110010, meaning the correct fetch-lock key.
REQ-004 SHALL provide ports, one per line:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  read data valid, in request order
imem_rsp_data  in  32  instruction word
redirect  in  1  branch/jump taken, flush
redirect_pc  in  32  new fetch address
instr_valid  out  1  buffered instruction available to decode
instr_ready  in  1  decode consumes instruction
instr  out  32  instruction word, FIFO head
pc_out  out  32  PC of instr
pc_plus4  out  32  pc_out + 4
op  out  7  instr[6:0], post-lock
funct3  out  3  instr[14:12]
funct7  out  7  instr[31:25]
key  in  8  fetch-lock key

Function
REQ-005 SHALL hold fetch PC register; imem_addr equals PC with bits [1:0] forced 0.
REQ-006 SHALL implement FSM {RST_HOLD, RUN, FLUSH}: RST_HOLD for exactly one cycle after rst deasserts, then RUN.
REQ-007 SHALL assert imem_req_valid in RUN only when outstanding + fifo_count < FIFO_DEPTH and redirect is low.
REQ-008 SHALL, on request handshake (valid & ready), increment PC by 4 and outstanding by 1; PC wraps 32'hFFFF_FFFC -> 0.
REQ-009 SHALL push imem_rsp_data with its PC into the FIFO on imem_rsp_valid, decrementing outstanding; simultaneous request and response SHALL leave outstanding unchanged.
REQ-010 SHALL present FIFO head combinationally on instr/pc_out/op/funct3/funct7; outputs SHALL stay stable while instr_valid & ~instr_ready.
REQ-011 SHALL pop on instr_valid & instr_ready; simultaneous push and pop when full SHALL succeed, count unchanged.
REQ-012 SHALL, on redirect, load PC with {redirect_pc[31:2],2'b00}, clear FIFO, set drop_count to outstanding (including any same-cycle handshake), and enter FLUSH; instr_valid SHALL be 0 the following cycle.
REQ-013 SHALL, in FLUSH, discard responses until drop_count reaches 0, then return to RUN; new requests SHALL be issued in FLUSH subject to REQ-007, with drop_count consumed before any buffer push.
REQ-014 SHALL give redirect priority over push, pop and PC increment in the same cycle.
REQ-015 SHALL treat response latency as arbitrary (at least 1 cycle) and never ignore imem_rsp_valid.

Reset
REQ-016 SHALL, with rst low, force PC=RESET_PC, FIFO empty, outstanding=0, drop_count=0, state=RST_HOLD, imem_req_valid=0, instr_valid=0.
REQ-017 SHALL discard all in-flight responses when reset asserts mid-operation; memory is reset together with the stage.

Configuration
REQ-018 SHALL, with FETCH_LOCK_EN defined, output op = instr[6:0] ^ (key[6:0] ^ KEY_FETCH[6:0]), so only the correct key yields true opcodes.
REQ-019 SHALL, without FETCH_LOCK_EN, output op = instr[6:0] and ignore key; the port remains.

Structure
REQ-020 SHALL place ILEN, NOP (32'h0000_0013), RESET_PC default and field bit positions in shared package rv32_pkg.
REQ-021 SHALL instantiate one sub-module fetch_fifo (parameterised depth, 64-bit entry {pc,instr}, count output).

Verification
REQ-022 Reset release, imem_req_ready=1, rsp latency 1 -> imem_addr sequence 0,4,8; first instr_valid on cycle 3 with pc_out=0.
REQ-023 instr_ready=0 for 10 cycles -> FIFO fills to 2, imem_req_valid drops, instr/pc_out constant at PC 0.
REQ-024 redirect with redirect_pc=32'h0000_0103 and 2 outstanding -> next imem_addr=32'h100; both stale responses dropped; first delivered pc_out=32'h100.
REQ-025 FETCH_LOCK_EN defined, imem word 32'h00500093: key=KEY_FETCH -> op=7'h13; key=8'h00 -> op=7'h13^7'h32.
REQ-026 Redirect asserted in the same cycle as a pop and a response -> FIFO empty next cycle, no stale instruction ever output.
REQ-027 rst asserted with 1 outstanding, released -> instr_valid=0 and first fetch at RESET_PC after one RST_HOLD cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: instruction fields, FSM states, buffer entries.
// Consumed by fetch_stage and fetch_fifo through import rv32_pkg::*.
package rv32_pkg;

  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

  // Wide enough for occupancy/credit counts of a 4-entry buffer
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    RST_HOLD,
    RUN,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc,instr} entries; head is read combinationally.
// Push into a full buffer succeeds only together with a pop.
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     din,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   slots [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push &&
                   ((count < CNT_W'(DEPTH)) || do_pop);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CNT_W'(do_push)
                     - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, credit-limited imem requests, in-order response buffer.
// Define FETCH_LOCK_EN to scramble op with the fetch-lock key.
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [7:0]  KEY_FETCH  = 8'b10110010
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  input  logic [7:0]  key
);

  localparam int IFW = CNT_W + 1;

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [31:0]      pc;
  logic [31:0]      pc_nxt;
  logic [31:0]      rsp_pc;
  logic [31:0]      rsp_pc_nxt;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] out_nxt;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] drop_nxt;
  logic [CNT_W-1:0] fifo_count;
  logic [IFW-1:0]   inflight;
  logic             active;
  logic             hs;
  logic             rsp_take;
  logic             dropping;
  logic             push;
  logic             pop;
  fetch_entry_t     din;
  fetch_entry_t     head;

  assign active   = (state == RUN) || (state == FLUSH);
  assign inflight = {1'b0, outstanding}
                  + {1'b0, fifo_count};
  assign dropping = drop_count != '0;
  assign rsp_take = imem_rsp_valid && (outstanding != '0);

  assign imem_req_valid = active && !redirect &&
                          (inflight < IFW'(FIFO_DEPTH));
  assign hs        = imem_req_valid && imem_req_ready;
  assign imem_addr = word_align(pc);

  // Stale responses are burned off before anything reaches the buffer
  assign push = rsp_take && !dropping && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    rsp_pc_nxt = rsp_pc;
    drop_nxt   = drop_count;
    out_nxt    = outstanding + CNT_W'(hs)
                             - CNT_W'(rsp_take);
    if (hs) begin
      pc_nxt = pc + 32'd4;
    end
    if (push) begin
      rsp_pc_nxt = rsp_pc + 32'd4;
    end
    if (rsp_take && dropping) begin
      drop_nxt = drop_count - CNT_W'(1);
    end
    unique case (state)
      RST_HOLD: state_nxt = RUN;
      RUN:      state_nxt = RUN;
      FLUSH: begin
        if (!dropping) begin
          state_nxt = RUN;
        end
      end
      default:  state_nxt = RST_HOLD;
    endcase
    if (redirect) begin
      pc_nxt     = word_align(redirect_pc);
      rsp_pc_nxt = word_align(redirect_pc);
      drop_nxt   = out_nxt;
      state_nxt  = FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RST_HOLD;
      pc          <= RESET_PC;
      rsp_pc      <= word_align(RESET_PC);
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      outstanding <= out_nxt;
      drop_count  <= drop_nxt;
    end
  end

  assign din.pc    = rsp_pc;
  assign din.instr = imem_rsp_data;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (fifo_count)
  );

  assign instr_valid = fifo_count != '0;
  assign instr       = head.instr;
  assign pc_out      = head.pc;
  assign pc_plus4    = head.pc + 32'd4;
  assign funct3      = instr[F3_MSB:F3_LSB];
  assign funct7      = instr[F7_MSB:F7_LSB];

`ifdef FETCH_LOCK_EN
  logic unused_key;
  assign unused_key = key[7];
  assign op = instr[OP_MSB:OP_LSB]
            ^ (key[6:0] ^ KEY_FETCH[6:0]);
`else
  logic unused_key;
  assign unused_key = ^key;
  assign op = instr[OP_MSB:OP_LSB];
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model plus a PC scoreboard.
// Expected instructions are queued on request and compared on pop.
module tb_fetch_stage;
  import rv32_pkg::*;

  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [7:0]  KEYF = 8'b10110010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [7:0]  key = KEYF;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (2),
    .KEY_FETCH  (KEYF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7),
    .key            (key)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[23:0], a[7:0]};
  endfunction

  // In-order memory with per-request latency
  int          lat_fix  = 1;
  bit          lat_rand = 1'b0;
  int unsigned now      = 0;
  int unsigned last_due = 0;
  int unsigned due_v;
  logic [31:0] pend_a[$];
  int unsigned pend_t[$];

  always @(posedge clk) begin
    now++;
    if (!rst) begin
      pend_a.delete();
      pend_t.delete();
      last_due = 0;
      imem_rsp_valid <= 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        due_v = now - 1 + (lat_rand ? $urandom_range(1, 3)
                                    : lat_fix);
        if (due_v <= last_due) due_v = last_due + 1;
        last_due = due_v;
        pend_a.push_back(imem_addr);
        pend_t.push_back(due_v);
      end
      if (pend_t.size() != 0 && pend_t[0] <= now) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(pend_a[0]);
        void'(pend_a.pop_front());
        void'(pend_t.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  // Scoreboard: PCs requested since last redirect, delivered in order
  logic [31:0] exp_q[$];
  logic [31:0] hs_log[$];
  logic [31:0] exp_pc = RPC;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;
  logic [31:0] e_pc;
  logic [31:0] e_w;
  logic [6:0]  e_op;
  logic [7:0]  keyf_v = KEYF;
  bit          prev_stall = 1'b0;
  bit          prev_redir = 1'b0;
  int          pop_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_pc     = RPC;
      prev_stall = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_redir) begin
        total++;
        if (instr_valid !== 1'b0)
          $display("FAIL flush_valid: got %b want 0", instr_valid);
        else passed++;
      end
      if (prev_stall) begin
        total++;
        if (instr_valid !== 1'b1 || instr !== prev_instr ||
            pc_out !== prev_pc)
          $display("FAIL stall_stable: got v=%b %h@%h want 1 %h@%h",
                   instr_valid, instr, pc_out, prev_instr, prev_pc);
        else passed++;
      end
      if (redirect) begin
        total++;
        if (imem_req_valid !== 1'b0)
          $display("FAIL redir_req: got %b want 0", imem_req_valid);
        else passed++;
        exp_q.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (instr_valid && instr_ready) begin
          total++;
          pop_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL pop_extra: got pc %h want none", pc_out);
          end else begin
            e_pc = exp_q.pop_front();
            e_w  = mem_word(e_pc);
`ifdef FETCH_LOCK_EN
            e_op = e_w[6:0] ^ (key[6:0] ^ keyf_v[6:0]);
`else
            e_op = e_w[6:0];
`endif
            if (pc_out !== e_pc || instr !== e_w ||
                pc_plus4 !== e_pc + 32'd4 || op !== e_op ||
                funct3 !== e_w[14:12] || funct7 !== e_w[31:25])
              $display("FAIL pop: got %h@%h op %h want %h@%h op %h",
                       instr, pc_out, op, e_w, e_pc, e_op);
            else passed++;
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          total++;
          if (imem_addr !== exp_pc)
            $display("FAIL req_addr: got %h want %h", imem_addr, exp_pc);
          else passed++;
          exp_q.push_back(exp_pc);
          hs_log.push_back(imem_addr);
          exp_pc = exp_pc + 32'd4;
        end
      end
      prev_redir = redirect;
      prev_stall = instr_valid && !instr_ready && !redirect;
      prev_instr = instr;
      prev_pc    = pc_out;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    redirect = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    hs_log.delete();
  endtask

  task automatic test_reset();
    lat_rand = 0; lat_fix = 1;
    instr_ready = 1; imem_req_ready = 1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL reset_valids: got %b%b want 00",
               imem_req_valid, instr_valid);
    else passed++;
    total++;
    if (imem_addr !== RPC)
      $display("FAIL reset_addr: got %h want %h", imem_addr, RPC);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b0)
      $display("FAIL rst_hold: got %b want 0", imem_req_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RPC)
      $display("FAIL first_req: got %b %h want 1 %h",
               imem_req_valid, imem_addr, RPC);
    else passed++;
  endtask

  task automatic test_fetch_seq();
    int first = -1;
    logic [31:0] fpc = 'x;
    lat_rand = 0; lat_fix = 1; instr_ready = 1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (instr_valid && first < 0) begin
        first = c;
        fpc   = pc_out;
      end
    end
    total++;
    if (first != 3 || fpc !== 32'h0)
      $display("FAIL first_instr: got cyc %0d pc %h want 3 0", first, fpc);
    else passed++;
    total++;
    if (hs_log.size() < 3)
      $display("FAIL addr_seq: got %0d reqs want >=3", hs_log.size());
    else if (hs_log[0] !== 32'h0 || hs_log[1] !== 32'h4 ||
             hs_log[2] !== 32'h8)
      $display("FAIL addr_seq: got %h %h %h want 0 4 8",
               hs_log[0], hs_log[1], hs_log[2]);
    else passed++;
  endtask

  task automatic test_stall();
    lat_rand = 0; lat_fix = 1; instr_ready = 0;
    do_reset();
    repeat (10) @(negedge clk);
    total++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h0 ||
        instr !== mem_word(32'h0) || imem_req_valid !== 1'b0)
      $display("FAIL stall_full: got v%b pc %h req %b want v1 pc 0 req 0",
               instr_valid, pc_out, imem_req_valid);
    else passed++;
    total++;
    if (hs_log.size() != 2)
      $display("FAIL stall_reqs: got %0d want 2", hs_log.size());
    else passed++;
    @(posedge clk);
    #1 instr_ready = 1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_redirect();
    int n = 0;
    lat_rand = 0; lat_fix = 4; instr_ready = 1;
    do_reset();
    while (pend_a.size() < 2 && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (pend_a.size() < 2)
      $display("FAIL redir_setup: got %0d outstanding want 2",
               pend_a.size());
    else passed++;
    @(posedge clk);
    #1;
    redirect    = 1;
    redirect_pc = 32'h0000_0103;
    @(posedge clk);
    #1;
    redirect = 0;
    hs_log.delete();
    @(negedge clk);
    total++;
    if (imem_addr !== 32'h100)
      $display("FAIL redir_addr: got %h want 100", imem_addr);
    else passed++;
    n = 0;
    while (!instr_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!instr_valid || pc_out !== 32'h100)
      $display("FAIL redir_first: got v%b pc %h want v1 100",
               instr_valid, pc_out);
    else passed++;
    total++;
    if (hs_log.size() == 0 || hs_log[0] !== 32'h100)
      $display("FAIL redir_req: got %0d reqs want first 100",
               hs_log.size());
    else passed++;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_redirect_pop_rsp();
    int n = 0;
    bit hit = 0;
    lat_rand = 0; lat_fix = 1; instr_ready = 1;
    do_reset();
    while (!hit && n < 20) begin
      @(posedge clk);
      #1;
      hit = imem_rsp_valid && instr_valid;
      n++;
    end
    total++;
    if (!hit) $display("FAIL rpr_setup: got no overlap want overlap");
    else passed++;
    redirect    = 1;
    redirect_pc = 32'h0000_0200;
    @(posedge clk);
    #1;
    redirect = 0;
    total++;
    if (instr_valid !== 1'b0)
      $display("FAIL rpr_empty: got %b want 0", instr_valid);
    else passed++;
    n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!instr_valid || pc_out !== 32'h200)
      $display("FAIL rpr_first: got v%b pc %h want v1 200",
               instr_valid, pc_out);
    else passed++;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    lat_rand = 0; lat_fix = 3; instr_ready = 1;
    do_reset();
    while (pend_a.size() == 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0)
      $display("FAIL mid_rst: got %b%b want 00",
               instr_valid, imem_req_valid);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL mid_hold: got %b%b want 00",
               imem_req_valid, instr_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RPC)
      $display("FAIL mid_first: got %b %h want 1 %h",
               imem_req_valid, imem_addr, RPC);
    else passed++;
    repeat (12) @(posedge clk);
  endtask

  task automatic test_lock();
    int n = 0;
    logic [6:0] want;
    lat_rand = 0; lat_fix = 1; instr_ready = 0; key = KEYF;
    do_reset();
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (pc_out !== 32'h0 || op !== 7'h13)
      $display("FAIL lock_good: got pc %h op %h want 0 13", pc_out, op);
    else passed++;
    @(posedge clk);
    #1 key = 8'h00;
    #1;
`ifdef FETCH_LOCK_EN
    want = 7'h13 ^ 7'h32;
`else
    want = 7'h13;
`endif
    total++;
    if (op !== want)
      $display("FAIL lock_bad: got op %h want %h", op, want);
    else passed++;
    @(posedge clk);
    #1;
    key = KEYF;
    instr_ready = 1;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_wrap();
    lat_rand = 0; lat_fix = 1; instr_ready = 1;
    do_reset();
    @(posedge clk);
    #1;
    redirect    = 1;
    redirect_pc = 32'hFFFF_FFFA;
    @(posedge clk);
    #1;
    redirect = 0;
    hs_log.delete();
    repeat (12) @(posedge clk);
    total++;
    if (hs_log.size() < 3)
      $display("FAIL wrap: got %0d reqs want >=3", hs_log.size());
    else if (hs_log[0] !== 32'hFFFF_FFF8 ||
             hs_log[1] !== 32'hFFFF_FFFC || hs_log[2] !== 32'h0)
      $display("FAIL wrap: got %h %h %h want fffffff8 fffffffc 0",
               hs_log[0], hs_log[1], hs_log[2]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int base;
    lat_rand = 1;
    do_reset();
    base = pop_cnt;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      instr_ready    = $urandom_range(0, 3) != 0;
      imem_req_ready = $urandom_range(0, 3) != 0;
      redirect       = $urandom_range(0, 29) == 0;
      redirect_pc    = $urandom & 32'h0000_0FFF;
    end
    @(posedge clk);
    #1;
    redirect = 0; instr_ready = 1; imem_req_ready = 1;
    repeat (20) @(posedge clk);
    total++;
    if (pop_cnt - base < 40)
      $display("FAIL b2b_progress: got %0d pops want >=40",
               pop_cnt - base);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fetch_seq();
    test_stall();
    test_redirect();
    test_redirect_pop_rsp();
    test_reset_mid();
    test_lock();
    test_wrap();
    test_back_to_back();
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
